// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Pure declarations: no logic, no latency.
// No flow control; consumers sample strobes on the cycle they occur.
package uart_pkg;

  // Payload bits per 8N1 frame.
  localparam int DATA_BITS = 8;

  // 50 MHz system clock at 9600 baud.
  localparam int CLKS_PER_BIT_DEFAULT = 5208;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Latency: 2 clk cycles from input change to output change.
// No backpressure; the output simply follows the input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the async input through two flops; reset to the line's idle level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, centre-of-bit sampling.
// Latency: strobe 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx falling edge.
// No backpressure: rx_data holds the last good byte until the next good frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  output logic       rx_frame_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  // Last count of the half-bit wait that lands in the middle of the start bit.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  // Last count of a full bit period.
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  logic                 w_rxs;

  rx_state_t            r_state;
  rx_state_t            w_state_next;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_next;
  logic [IW-1:0]        r_bit_idx;
  logic [IW-1:0]        w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_next;
  logic                 r_ready;
  logic                 w_ready_next;
  logic                 r_ferr;
  logic                 w_ferr_next;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (rx),
    .o_q     (w_rxs)
  );

  // Register all FSM, datapath and strobe state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_ready   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_data    <= w_data_next;
      r_ready   <= w_ready_next;
      r_ferr    <= w_ferr_next;
    end
  end

  // Next-state, counter, shift and strobe decisions from the synchronised line.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_data_next    = r_data;
    w_ready_next   = 1'b0;
    w_ferr_next    = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (!w_rxs) begin
          w_state_next = START;
        end
      end

      START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next = '0;
          if (!w_rxs) begin
            w_state_next   = DATA;
            w_bit_idx_next = '0;
          end else begin
            // Line came back high mid start bit: treat as noise.
            w_state_next = IDLE;
          end
        end
      end

      DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next              = '0;
          w_shift_next[r_bit_idx] = w_rxs;
          w_bit_idx_next          = r_bit_idx + 1'b1;
          if (r_bit_idx == IDX_LAST) begin
            w_state_next = STOP;
          end
        end
      end

      STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next = '0;
          if (w_rxs) begin
            // Returning to IDLE half a bit early lets a back-to-back start edge be caught.
            w_data_next  = r_shift;
            w_ready_next = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = BREAK;
          end
        end
      end

      BREAK: begin
        // Hold off until the line goes idle so a stuck-low line yields one error only.
        w_cnt_next = '0;
        if (w_rxs) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_cnt_next   = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  assign rx_data        = r_data;
  assign rx_data_ready  = r_ready;
  assign rx_frame_error = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit.
// Stimulus pushes expected byte/strobe cycle; a negedge monitor pops and compares.
// Missing strobes are detected by their expected cycle passing.
module tb_uart_rx;

  localparam int CPB = 16;
  // rx edge -> 2 sync flops -> half bit + 9 bits -> registered strobe.
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       rx_frame_error;

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx             (rx),
    .rx_data        (rx_data),
    .rx_data_ready  (rx_data_ready),
    .rx_frame_error (rx_frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Drive one frame starting at the current negedge; ends on a negedge after the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int extra_low);
    int   fall;
    exp_t e;
    fall = cyc;
    if (stop_ok) begin
      e.data = d;
      e.at   = fall + LAT;
      exp_q.push_back(e);
    end else begin
      err_q.push_back(fall + LAT);
    end
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    if (!stop_ok) begin
      repeat (extra_low) @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Monitor: compare every strobe against the scoreboard, flag overdue entries.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   at;
    if (rx_data_ready && rx_frame_error) flag("both_strobes_high");

    if (rx_data_ready) begin
      if (exp_q.size() == 0) begin
        flag("unexpected_ready");
      end else begin
        e = exp_q.pop_front();
        check("rx_data_on_ready", 32'(rx_data), 32'(e.data));
        check("ready_cycle", 32'(cyc), 32'(e.at));
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
      e = exp_q.pop_front();
      flag("missing_ready");
    end

    if (rx_frame_error) begin
      if (err_q.size() == 0) begin
        flag("unexpected_frame_error");
      end else begin
        at = err_q.pop_front();
        check("frame_error_cycle", 32'(cyc), 32'(at));
      end
    end else if (err_q.size() > 0 && cyc > err_q[0]) begin
      at = err_q.pop_front();
      flag("missing_frame_error");
    end
  end

  initial begin
    // 1. Reset and quiet idle line.
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_ready", 32'(rx_data_ready), 32'h0);
    check("reset_ferr", 32'(rx_frame_error), 32'h0);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("idle_rx_data", 32'(rx_data), 32'h00);

    // 2. Single frame.
    send_frame(8'h08, 1'b1, 0);
    repeat (40) @(negedge clk);
    check("single_rx_data", 32'(rx_data), 32'h08);

    // 3. Back-to-back frames, no idle gap.
    send_frame(8'h08, 1'b1, 0);
    send_frame(8'h09, 1'b1, 0);
    send_frame(8'h0A, 1'b1, 0);
    repeat (40) @(negedge clk);
    check("b2b_last_rx_data", 32'(rx_data), 32'h0A);

    // 4. Short low glitch is rejected.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_rx_data", 32'(rx_data), 32'h0A);

    // 5. Good frame, then a frame with a low stop bit and a held-low line, then recovery.
    send_frame(8'h09, 1'b1, 0);
    send_frame(8'h3C, 1'b0, 40);
    repeat (40) @(negedge clk);
    check("ferr_rx_data_kept", 32'(rx_data), 32'h09);
    send_frame(8'h55, 1'b1, 0);
    repeat (40) @(negedge clk);
    check("recover_rx_data", 32'(rx_data), 32'h55);

    // 6. Reset asserted during data bit 4 of 0xFF.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_rx_data", 32'(rx_data), 32'h00);
    check("midreset_ready", 32'(rx_data_ready), 32'h0);
    check("midreset_ferr", 32'(rx_frame_error), 32'h0);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    send_frame(8'hA5, 1'b1, 0);
    repeat (40) @(negedge clk);
    check("after_reset_rx_data", 32'(rx_data), 32'hA5);

    // Everything issued must have been seen.
    repeat (20) @(negedge clk);
    check("pending_ready", 32'(exp_q.size()), 32'd0);
    check("pending_ferr", 32'(err_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
